// File: rtl/seq_div_pkg.sv
// ---------------------------------------------------------------------------
// seq_div_pkg
// Shared constants and types for the 16/8 sequential restoring divider.
//   DW          : dividend / quotient width
//   VW          : divisor / remainder width
//   CW          : iteration counter width (2^CW must cover DW iterations)
//   state_t     : controller states IDLE, CALC, DONE
//   DZ_QUOTIENT : quotient reported when the divisor is zero (all ones)
// ---------------------------------------------------------------------------
package seq_div_pkg;

    localparam int DW = 16;
    localparam int VW = 8;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration. The partial remainder is
// shifted left with the next dividend bit, and the divisor is subtracted
// when it fits.
// Ports:
//   i_rem   : current partial remainder (VW bits)
//   i_aMsb  : next dividend bit shifted into the remainder
//   i_div   : divisor (VW bits)
//   o_rem   : next partial remainder (VW bits)
//   o_qBit  : quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module div_step
    import seq_div_pkg::*;
(
    input  logic [VW-1:0] i_rem,
    input  logic          i_aMsb,
    input  logic [VW-1:0] i_div,
    output logic [VW-1:0] o_rem,
    output logic          o_qBit
);

    logic [VW:0] w_trial;

    assign w_trial = {i_rem, i_aMsb};

    // The trial value needs VW+1 bits; the divisor is zero-extended so the
    // compare is unsigned and exact.
    assign o_qBit = (w_trial >= {1'b0, i_div});

    // When the divisor fits, the difference is below the divisor and so fits
    // in VW bits; dropping the top bit of the trial value is therefore exact.
    assign o_rem = o_qBit ? (w_trial[VW-1:0] - i_div) : w_trial[VW-1:0];

endmodule

// File: rtl/seq_div16x8.sv
// ---------------------------------------------------------------------------
// seq_div16x8
// Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned
// divisor, one quotient bit per clock, start/done handshake.
// Ports:
//   i_clk         : rising-edge clock
//   i_reset_a     : asynchronous active-high reset
//   i_start       : request a new division (accepted in IDLE or DONE)
//   i_dividend    : dividend, sampled on the accepting edge
//   i_divisor     : divisor, sampled on the accepting edge
//   o_quotient    : registered quotient, valid while o_done_flag is high
//   o_remainder   : registered remainder, valid while o_done_flag is high
//   o_done_flag   : result valid, held until the next accepted start
//   o_busy        : high while iterating
//   o_div_by_zero : high with o_done_flag when the divisor was zero
// ---------------------------------------------------------------------------
module seq_div16x8
    import seq_div_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset_a,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic [DW-1:0] o_quotient,
    output logic [VW-1:0] o_remainder,
    output logic          o_done_flag,
    output logic          o_busy,
    output logic          o_div_by_zero
);

    state_t        r_state;
    logic [DW-1:0] r_a;
    logic [VW-1:0] r_d;
    logic [VW-1:0] r_r;
    logic [CW-1:0] r_count;
    logic          r_dzPending;

    logic [VW-1:0] w_nextRem;
    logic          w_qBit;
    logic [DW-1:0] w_nextA;

    div_step u_step (
        .i_rem  (r_r),
        .i_aMsb (r_a[DW-1]),
        .i_div  (r_d),
        .o_rem  (w_nextRem),
        .o_qBit (w_qBit)
    );

    // A doubles as the shift register: dividend bits leave at the top while
    // quotient bits enter at the bottom, so after DW steps it holds the quotient.
    assign w_nextA = {r_a[DW-2:0], w_qBit};

    // Controller and datapath registers. A zero divisor parks in DONE with a
    // pending flag so the result appears one edge after the accepting edge.
    always_ff @(posedge i_clk or posedge i_reset_a) begin
        if (i_reset_a) begin
            r_state       <= IDLE;
            r_a           <= '0;
            r_d           <= '0;
            r_r           <= '0;
            r_count       <= '0;
            r_dzPending   <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_done_flag   <= 1'b0;
            o_busy        <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_a           <= i_dividend;
                        r_d           <= i_divisor;
                        r_r           <= '0;
                        r_count       <= '0;
                        o_done_flag   <= 1'b0;
                        o_div_by_zero <= 1'b0;
                        if (i_divisor == '0) begin
                            r_state     <= DONE;
                            r_dzPending <= 1'b1;
                            o_busy      <= 1'b0;
                        end else begin
                            r_state     <= CALC;
                            r_dzPending <= 1'b0;
                            o_busy      <= 1'b1;
                        end
                    end else if (r_dzPending) begin
                        r_dzPending   <= 1'b0;
                        o_quotient    <= DZ_QUOTIENT;
                        o_remainder   <= r_a[VW-1:0];
                        o_div_by_zero <= 1'b1;
                        o_done_flag   <= 1'b1;
                    end
                end
                CALC: begin
                    r_r     <= w_nextRem;
                    r_a     <= w_nextA;
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(DW - 1)) begin
                        r_state     <= DONE;
                        o_quotient  <= w_nextA;
                        o_remainder <= w_nextRem;
                        o_done_flag <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div16x8.sv
// ---------------------------------------------------------------------------
// tb_seq_div16x8
// Self-checking bench for seq_div16x8. Stimulus pushes hand-computed results
// into a queue; a monitor pops and compares on each rising done_flag.
// ---------------------------------------------------------------------------
module tb_seq_div16x8;

    typedef struct packed {
        logic [15:0] quotient;
        logic [7:0]  remainder;
        logic        divByZero;
    } expect_t;

    logic        clk;
    logic        resetA;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        doneFlag;
    logic        busy;
    logic        divByZero;

    expect_t     expQueue[$];
    int          passCount;
    int          checkCount;
    logic        prevDone;

    seq_div16x8 dut (
        .i_clk         (clk),
        .i_reset_a     (resetA),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_done_flag   (doneFlag),
        .o_busy        (busy),
        .o_div_by_zero (divByZero)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single compare point used by stimulus and monitor alike
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checkCount++;
        if (actual === required) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Issue one division, push its expected result, and time the done latency
    task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs,
                                 input logic [15:0] expQ, input logic [7:0] expR,
                                 input logic expDz, input int expLatency);
        expect_t e;
        int cycles;
        e.quotient  = expQ;
        e.remainder = expR;
        e.divByZero = expDz;
        expQueue.push_back(e);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("done cleared after start", 32'(doneFlag), 32'd0);
        checkOutput("busy after start", 32'(busy), (dvs != 8'd0) ? 32'd1 : 32'd0);
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (doneFlag) break;
        end
        checkOutput("done latency", 32'(cycles), 32'(expLatency));
        checkOutput("busy at done", 32'(busy), 32'd0);
    endtask

    // Monitor: compare against the scoreboard whenever a result appears
    always @(negedge clk) begin
        if (resetA) begin
            prevDone <= 1'b0;
        end else begin
            prevDone <= doneFlag;
            if (doneFlag && !prevDone) begin
                if (expQueue.size() == 0) begin
                    checkOutput("unexpected result", 32'd1, 32'd0);
                end else begin
                    expect_t e;
                    e = expQueue.pop_front();
                    checkOutput("quotient", 32'(quotient), 32'(e.quotient));
                    checkOutput("remainder", 32'(remainder), 32'(e.remainder));
                    checkOutput("div_by_zero", 32'(divByZero), 32'(e.divByZero));
                end
            end
        end
    end

    initial begin
        passCount  = 0;
        checkCount = 0;
        prevDone   = 1'b0;
        start      = 1'b0;
        dividend   = '0;
        divisor    = '0;
        resetA     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset quotient", 32'(quotient), 32'd0);
        checkOutput("reset remainder", 32'(remainder), 32'd0);
        checkOutput("reset done", 32'(doneFlag), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset dz", 32'(divByZero), 32'd0);
        resetA = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(16'd100,  8'd7,    16'd14,     8'd2,    1'b0, 16);
        applyStimulus(16'hFE01, 8'hFF,   16'h00FF,   8'd0,    1'b0, 16);
        applyStimulus(16'hFFFF, 8'd1,    16'hFFFF,   8'd0,    1'b0, 16);
        applyStimulus(16'h1234, 8'd0,    16'hFFFF,   8'h34,   1'b1, 1);
        applyStimulus(16'd5,    8'd9,    16'd0,      8'd5,    1'b0, 16);
        applyStimulus(16'd1000, 8'd10,   16'd100,    8'd0,    1'b0, 16);

        // Aborted operation: start ignored mid-calc, then reset
        dividend = 16'h8000;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'hFFFF;
        divisor  = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy after ignored start", 32'(busy), 32'd1);
        checkOutput("quotient held during calc", 32'(quotient), 32'd100);
        repeat (2) @(posedge clk);
        #1;
        resetA = 1'b1;
        #1;
        checkOutput("mid reset quotient", 32'(quotient), 32'd0);
        checkOutput("mid reset remainder", 32'(remainder), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset done", 32'(doneFlag), 32'd0);
        @(posedge clk);
        #1;
        resetA = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(16'h8000, 8'd3,    16'h2AAA,   8'd2,    1'b0, 16);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(expQueue.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
